ram512x8_wb_bridge: RTL and testbench

Wishbone-classic 32-bit slave that serialises word accesses onto the 8-bit `ram512x8` macro wrapper. Each bus access becomes four byte-wide RAM cycles, little-endian, honouring byte selects. Sits directly upstream of `ram512x8`; the parent instantiates both and wires `ram_*` ports straight to the RAM's `wen_i`/`adr_i`/`dat_i`/`dat_o`. Exposes a 128-word (512-byte) memory to the CPU bus.

---
 rtl/ram512x8_wb_pkg.sv | 32 +++
 rtl/ram512x8_wb_lane_next.sv | 22 ++
 rtl/ram512x8_wb_bridge.sv | 192 +++++++++++++++++++
 tb/tb_ram512x8_wb_bridge.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ram512x8_wb_pkg.sv
// Shared types and geometry for the Wishbone-to-ram512x8 byte-serialising bridge.
package ram512x8_wb_pkg;

    localparam int unsigned LANES   = 4;
    localparam int unsigned WORD_AW = 7;
    localparam int unsigned BYTE_AW = 9;
    localparam int unsigned LANE_W  = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned DW      = 32;
    localparam int unsigned BW      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ACK   = 2'd3
    } bridge_state_e;

    // Little-endian byte lane extraction from a bus word.
    function automatic logic [BW-1:0] lane_byte(input logic [DW-1:0] word,
                                                 input logic [LANE_W-1:0] lane);
        logic [BW-1:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ram512x8_wb_lane_next.sv
// Finds the lowest selected byte lane at or above from_lane; found_c low if none remain.
module ram512x8_wb_lane_next
    import ram512x8_wb_pkg::*;
(
    input  logic [LANES-1:0]  sel,
    input  logic [CNT_W-1:0]  from_lane,
    output logic              found_c,
    output logic [LANE_W-1:0] lane_c
);

    always_comb begin
        found_c = 1'b0;
        lane_c  = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (!found_c && sel[i] && (CNT_W'(i) >= from_lane)) begin
                found_c = 1'b1;
                lane_c  = LANE_W'(i);
            end
        end
    end

endmodule

// File: rtl/ram512x8_wb_bridge.sv
// Wishbone-classic 32-bit slave serialising word accesses onto the 8-bit ram512x8 macro.
// Define RAM512X8_WB_LANE_SKIP_EN to make writes visit only the selected byte lanes.
module ram512x8_wb_bridge
    import ram512x8_wb_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [WORD_AW-1:0] wb_adr_i,
    input  logic [LANES-1:0]   wb_sel_i,
    input  logic [DW-1:0]      wb_dat_i,
    output logic [DW-1:0]      wb_dat_o,
    output logic               wb_ack_o,
    output logic               ram_wen_o,
    output logic [BYTE_AW-1:0] ram_adr_o,
    output logic [BW-1:0]      ram_dat_o,
    input  logic [BW-1:0]      ram_dat_i
);

    bridge_state_e      state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_AW-1:0] adr_q, adr_d;
    logic [LANES-1:0]   sel_q, sel_d;
    logic [DW-1:0]      wdat_q, wdat_d;
    logic [23:0]        rd_buf_q, rd_buf_d;
    logic [DW-1:0]      rdat_q, rdat_d;
    logic               ack_q, ack_d;
    logic               wen_q, wen_d;
    logic [BYTE_AW-1:0] ram_adr_q, ram_adr_d;
    logic [BW-1:0]      ram_dat_q, ram_dat_d;
    logic [LANE_W-1:0]  step_lane;

`ifdef RAM512X8_WB_LANE_SKIP_EN
    logic [LANES-1:0]   find_sel;
    logic [CNT_W-1:0]   find_from;
    logic               nxt_found;
    logic [LANE_W-1:0]  nxt_lane;

    // One finder serves both the first lane at accept and the following lane in WRITE.
    assign find_sel  = (state_q == IDLE) ? wb_sel_i : sel_q;
    assign find_from = (state_q == IDLE) ? CNT_W'(0) : CNT_W'(cnt_q + CNT_W'(1));

    ram512x8_wb_lane_next u_lane_next (
        .sel       (find_sel),
        .from_lane (find_from),
        .found_c   (nxt_found),
        .lane_c    (nxt_lane)
    );
`endif

    assign step_lane = LANE_W'(cnt_q + CNT_W'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        wdat_d    = wdat_q;
        rd_buf_d  = rd_buf_q;
        rdat_d    = rdat_q;
        ack_d     = 1'b0;
        wen_d     = 1'b0;
        ram_adr_d = ram_adr_q;
        ram_dat_d = ram_dat_q;

        case (state_q)
            IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d  = wb_adr_i;
                    sel_d  = wb_sel_i;
                    wdat_d = wb_dat_i;
                    cnt_d  = '0;
                    if (wb_we_i) begin
`ifdef RAM512X8_WB_LANE_SKIP_EN
                        if (nxt_found) begin
                            state_d   = WRITE;
                            cnt_d     = CNT_W'(nxt_lane);
                            ram_adr_d = {wb_adr_i, nxt_lane};
                            ram_dat_d = lane_byte(wb_dat_i, nxt_lane);
                            wen_d     = 1'b1;
                        end else begin
                            state_d = ACK;
                            ack_d   = 1'b1;
                        end
`else
                        state_d   = WRITE;
                        ram_adr_d = {wb_adr_i, 2'b00};
                        ram_dat_d = wb_dat_i[7:0];
                        wen_d     = wb_sel_i[0];
`endif
                    end else begin
                        state_d   = READ;
                        ram_adr_d = {wb_adr_i, 2'b00};
                    end
                end
            end

            WRITE: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
`ifdef RAM512X8_WB_LANE_SKIP_EN
                end else if (nxt_found) begin
                    cnt_d     = CNT_W'(nxt_lane);
                    ram_adr_d = {adr_q, nxt_lane};
                    ram_dat_d = lane_byte(wdat_q, nxt_lane);
                    wen_d     = 1'b1;
                end else begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end
`else
                end else if (cnt_q[1:0] == 2'd3) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d     = CNT_W'(cnt_q + CNT_W'(1));
                    ram_adr_d = {adr_q, step_lane};
                    ram_dat_d = lane_byte(wdat_q, step_lane);
                    wen_d     = sel_q[step_lane];
                end
`endif
            end

            // Capture lags the address by one cycle; lane 3 lands straight in the output word.
            READ: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    case (cnt_q)
                        3'd1:    rd_buf_d[7:0]   = ram_dat_i;
                        3'd2:    rd_buf_d[15:8]  = ram_dat_i;
                        3'd3:    rd_buf_d[23:16] = ram_dat_i;
                        3'd4: begin
                            rdat_d  = {ram_dat_i, rd_buf_q};
                            state_d = ACK;
                            ack_d   = 1'b1;
                        end
                        default: ;
                    endcase
                    if (cnt_q < CNT_W'(4)) begin
                        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                    end
                    if (cnt_q < CNT_W'(3)) begin
                        ram_adr_d = {adr_q, step_lane};
                    end
                end
            end

            ACK: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            adr_q     <= '0;
            sel_q     <= '0;
            wdat_q    <= '0;
            rd_buf_q  <= '0;
            rdat_q    <= '0;
            ack_q     <= 1'b0;
            wen_q     <= 1'b0;
            ram_adr_q <= '0;
            ram_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            wdat_q    <= wdat_d;
            rd_buf_q  <= rd_buf_d;
            rdat_q    <= rdat_d;
            ack_q     <= ack_d;
            wen_q     <= wen_d;
            ram_adr_q <= ram_adr_d;
            ram_dat_q <= ram_dat_d;
        end
    end

    // Gating with the live cycle signal stops the byte write in the very cycle the master aborts.
    assign ram_wen_o = wen_q & wb_cyc_i;
    assign ram_adr_o = ram_adr_q;
    assign ram_dat_o = ram_dat_q;
    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = rdat_q;

endmodule

// File: tb/tb_ram512x8_wb_bridge.sv
// Self-checking bench for ram512x8_wb_bridge with a behavioural ram512x8 and a write/read scoreboard.
module tb_ram512x8_wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [6:0]  wb_adr_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        ram_wen_o;
    logic [8:0]  ram_adr_o;
    logic [7:0]  ram_dat_o;
    logic [7:0]  ram_rd = '0;

    typedef struct {
        int         cyc;
        logic [8:0] adr;
        logic [7:0] dat;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [31:0] rd_q[$];
    logic [7:0]  ram_mem [512];
    logic [7:0]  exp_mem [512];
    int          cyc_n = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    ram512x8_wb_bridge dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_sel_i  (wb_sel_i),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .ram_wen_o (ram_wen_o),
        .ram_adr_o (ram_adr_o),
        .ram_dat_o (ram_dat_o),
        .ram_dat_i (ram_rd)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    // Behavioural ram512x8: synchronous write, registered read.
    always @(posedge clk_i) begin
        if (ram_wen_o === 1'b1) ram_mem[ram_adr_o] <= ram_dat_o;
        ram_rd <= ram_mem[ram_adr_o];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // Every RAM write strobe must match the next expected byte write, in order and on time.
    always @(negedge clk_i) begin
        if (ram_wen_o === 1'b1) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 32'(ram_wen_o), 32'd0);
            end else begin
                wr_exp_t e;
                e = wr_q.pop_front();
                check("wr_cycle", 32'(cyc_n), 32'(e.cyc));
                check("wr_adr", 32'(ram_adr_o), 32'(e.adr));
                check("wr_dat", 32'(ram_dat_o), 32'(e.dat));
            end
        end
    end

    function automatic logic [31:0] word_of(input logic [6:0] adr);
        return {exp_mem[{adr, 2'd3}], exp_mem[{adr, 2'd2}], exp_mem[{adr, 2'd1}], exp_mem[{adr, 2'd0}]};
    endfunction

    task automatic push_writes(input int c0, input logic [6:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat, output int ack_at);
        int slot;
        int at;
        slot = 0;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
`ifdef RAM512X8_WB_LANE_SKIP_EN
                at = c0 + 1 + slot;
`else
                at = c0 + 1 + i;
`endif
                wr_q.push_back('{cyc: at, adr: {adr, 2'(i)}, dat: dat[8*i +: 8]});
                exp_mem[{adr, 2'(i)}] = dat[8*i +: 8];
                slot++;
            end
        end
`ifdef RAM512X8_WB_LANE_SKIP_EN
        ack_at = slot + 1;
`else
        ack_at = 5;
`endif
    endtask

    task automatic wb_xfer(input logic we, input logic [6:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat);
        int c0;
        int ack_at;
        bit got;
        got = 0;
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
        c0 = cyc_n;
        if (we) begin
            push_writes(c0, adr, sel, dat, ack_at);
        end else begin
            rd_q.push_back(word_of(adr));
            ack_at = 6;
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk_i);
            if (wb_ack_o === 1'b1) begin
                got = 1;
                check(we ? "wr_ack_cycle" : "rd_ack_cycle", 32'(cyc_n - c0), 32'(ack_at));
                if (!we) check("rd_data", wb_dat_o, rd_q.pop_front());
            end
        end
        if (!got) check("ack_timeout", 32'(wb_ack_o), 32'd1);
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk_i);
        check("ack_single", 32'(wb_ack_o), 32'd0);
    endtask

    initial begin
        int c0;
        logic [31:0] held;
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_wen", 32'(ram_wen_o), 32'd0);
        check("rst_radr", 32'(ram_adr_o), 32'd0);
        check("rst_rdat", 32'(ram_dat_o), 32'd0);

        wb_xfer(1'b1, 7'd5, 4'b1111, 32'hDEAD_BEEF);
        wb_xfer(1'b0, 7'd5, 4'b1111, 32'h0);
        wb_xfer(1'b1, 7'd5, 4'b0101, 32'h1122_3344);
        wb_xfer(1'b0, 7'd5, 4'b0000, 32'h0);
        wb_xfer(1'b1, 7'd127, 4'b1111, 32'h0A0B_0C0D);
        wb_xfer(1'b0, 7'd127, 4'b1111, 32'h0);

        // Master drops cyc in cycle 3 of a full write: only lanes 0 and 1 land.
        held = wb_dat_o;
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 7'd3; wb_sel_i = 4'b1111; wb_dat_i = 32'hCAFE_F00D;
        c0 = cyc_n;
        wr_q.push_back('{cyc: c0 + 1, adr: 9'd12, dat: 8'h0D});
        wr_q.push_back('{cyc: c0 + 2, adr: 9'd13, dat: 8'hF0});
        exp_mem[12] = 8'h0D;
        exp_mem[13] = 8'hF0;
        repeat (3) @(posedge clk_i);
        #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("abort_no_ack", 32'(wb_ack_o), 32'd0);
        end
        check("abort_dat_held", wb_dat_o, held);
        wb_xfer(1'b0, 7'd3, 4'b1111, 32'h0);

        // Synchronous reset in cycle 3 of a read, with the master still holding the bus.
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 7'd127; wb_sel_i = 4'b1111;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            check("rst_mid_ack", 32'(wb_ack_o), 32'd0);
            check("rst_mid_dat", wb_dat_o, 32'd0);
            check("rst_mid_wen", 32'(ram_wen_o), 32'd0);
        end
        wb_xfer(1'b0, 7'd5, 4'b1111, 32'h0);

        wb_xfer(1'b1, 7'd9, 4'b1000, 32'h7700_0000);
        wb_xfer(1'b1, 7'd9, 4'b0000, 32'h1234_5678);
        wb_xfer(1'b0, 7'd9, 4'b1111, 32'h0);

        for (int n = 0; n < 12; n++) begin
            wb_xfer(1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
                    4'($urandom), $urandom);
        end

        repeat (3) @(negedge clk_i);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
